// File: rtl/m_unit_sched.sv
// Arbiter and latency tracker for the shared MUL/DIV unit between issue lanes 0 and 1.
// Lane 0 carries the older instruction and always wins; the result lane is announced on m_prio.
module m_unit_sched #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 34,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_is_div,
  input  logic       req1_valid,
  input  logic       req1_is_div,
  input  logic       ex_stall,
  input  logic       flush,
  output logic       grant0,
  output logic       grant1,
  output logic       stall0,
  output logic       stall1,
  output logic       m_start,
  output logic       m_op_div,
  output logic       m_busy,
  output logic [1:0] m_prio
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter is loaded with LAT-1 so that DONE lands exactly LAT cycles after the grant.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_t           state_r;
  state_t           nextState_s;
  logic [CNT_W-1:0] cnt_r;
  logic             laneQ_r;
  logic             divQ_r;
  logic [1:0]       prio_r;
  logic             busy_r;
  logic             grantOk_s;
  logic             grant0_s;
  logic             grant1_s;
  logic             grantDiv_s;

  // State, latency counter, captured op info and the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      laneQ_r <= 1'b0;
      divQ_r  <= 1'b0;
      prio_r  <= 2'b00;
      busy_r  <= 1'b0;
    end else begin
      state_r <= nextState_s;
      busy_r  <= (nextState_s != IDLE);
      prio_r  <= (nextState_s == DONE) ? {1'b1, laneQ_r} : 2'b00;
      if (grant0_s || grant1_s) begin
        cnt_r   <= grantDiv_s ? DIV_LOAD : MUL_LOAD;
        laneQ_r <= grant1_s;
        divQ_r  <= grantDiv_s;
      end else if (flush) begin
        cnt_r   <= CNT_ZERO;
        laneQ_r <= laneQ_r;
        divQ_r  <= divQ_r;
      end else if (state_r == BUSY) begin
        cnt_r   <= cnt_r - CNT_ONE;
        laneQ_r <= laneQ_r;
        divQ_r  <= divQ_r;
      end else begin
        cnt_r   <= cnt_r;
        laneQ_r <= laneQ_r;
        divQ_r  <= divQ_r;
      end
    end
  end

  // Next-state: flush beats everything, a stalled DONE holds the result.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (flush) begin
          nextState_s = IDLE;
        end else if (grant0_s || grant1_s) begin
          nextState_s = BUSY;
        end else begin
          nextState_s = IDLE;
        end
      end
      BUSY: begin
        if (flush) begin
          nextState_s = IDLE;
        end else if (cnt_r == CNT_ONE) begin
          nextState_s = DONE;
        end else begin
          nextState_s = BUSY;
        end
      end
      DONE: begin
        if (flush) begin
          nextState_s = IDLE;
        end else if (ex_stall) begin
          nextState_s = DONE;
        end else if (grant0_s || grant1_s) begin
          nextState_s = BUSY;
        end else begin
          nextState_s = IDLE;
        end
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // Grant arbitration and port outputs; grants are combinational so issue sees them same cycle.
  always_comb begin
    grantOk_s  = 1'b0;
    grantDiv_s = 1'b0;
    if ((state_r == IDLE || state_r == DONE) && !ex_stall && !flush && !rst) begin
      grantOk_s = 1'b1;
    end else begin
      grantOk_s = 1'b0;
    end
    grant0_s = grantOk_s & req0_valid;
    grant1_s = grantOk_s & req1_valid & ~req0_valid;
    if (grant0_s) begin
      grantDiv_s = req0_is_div;
    end else if (grant1_s) begin
      grantDiv_s = req1_is_div;
    end else begin
      grantDiv_s = 1'b0;
    end
    grant0   = grant0_s;
    grant1   = grant1_s;
    stall0   = req0_valid & ~grant0_s;
    stall1   = req1_valid & ~grant1_s;
    m_start  = grant0_s | grant1_s;
    m_op_div = grantDiv_s;
    m_busy   = busy_r;
    m_prio   = prio_r;
  end

endmodule

// File: tb/tb_m_unit_sched.sv
// Directed bench for m_unit_sched: a cycles-to-result model checked every cycle,
// plus hand-computed expectations for the scenarios listed with the design.
module tb_m_unit_sched;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 34;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req0_is_div = 1'b0, req1_valid = 1'b0, req1_is_div = 1'b0;
  logic       ex_stall = 1'b0, flush = 1'b0;
  logic       grant0, grant1, stall0, stall1, m_start, m_op_div, m_busy;
  logic [1:0] m_prio;

  int total = 0;
  int bad   = 0;
  bit en    = 1'b0;

  m_unit_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_is_div(req0_is_div),
    .req1_valid(req1_valid), .req1_is_div(req1_is_div),
    .ex_stall(ex_stall), .flush(flush),
    .grant0(grant0), .grant1(grant1), .stall0(stall0), .stall1(stall1),
    .m_start(m_start), .m_op_div(m_op_div), .m_busy(m_busy), .m_prio(m_prio)
  );

  always #5 clk = ~clk;

  // Model: an op in flight with a number of cycles left until its result is shown.
  bit mInFlight = 1'b0;
  int mRemain   = 0;
  bit mLane     = 1'b0;

  wire mReady   = mInFlight && (mRemain == 0);
  wire canGrant = !rst && !flush && !ex_stall && (!mInFlight || mReady);
  wire eG0      = canGrant && req0_valid;
  wire eG1      = canGrant && req1_valid && !req0_valid;
  wire eDiv     = eG0 ? req0_is_div : (eG1 ? req1_is_div : 1'b0);
  wire [1:0] ePrio = mReady ? {1'b1, mLane} : 2'b00;
  wire [5:0] eVec  = {eG0, eG1, eG0 | eG1, eDiv, req0_valid & !eG0, req1_valid & !eG1};

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, then advance the model by one cycle.
  always @(negedge clk) begin
    if (en) begin
      chk("outs", {2'b00, grant0, grant1, m_start, m_op_div, stall0, stall1}, {2'b00, eVec});
      chk("busy", {7'd0, m_busy}, {7'd0, mInFlight});
      chk("prio", {6'd0, m_prio}, {6'd0, ePrio});
    end
    if (rst || flush) begin
      mInFlight <= 1'b0;
      mRemain   <= 0;
    end else if (eG0 || eG1) begin
      mInFlight <= 1'b1;
      mRemain   <= (eDiv ? DIV_LAT : MUL_LAT) - 1;
      mLane     <= eG1;
    end else if (mInFlight && mRemain > 0) begin
      mRemain <= mRemain - 1;
    end else if (mInFlight && !ex_stall) begin
      mInFlight <= 1'b0;
    end
  end

  task automatic drive(input bit r0, input bit d0, input bit r1, input bit d1,
                       input bit st, input bit fl, input bit rs);
    req0_valid = r0; req0_is_div = d0; req1_valid = r1; req1_is_div = d1;
    ex_stall = st; flush = fl; rst = rs;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drive(0, 0, 0, 0, 0, 0, 1);
    next_cycle();
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    do_reset();
    en = 1'b1;
    @(negedge clk);
    chk("rst_busy", {7'd0, m_busy}, 8'd0);
    chk("rst_prio", {6'd0, m_prio}, 8'd0);
    next_cycle();

    // 1: single lane-0 multiply granted at c5
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      drive(c == 5, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      if (c == 5) chk("t1_grant0", {7'd0, grant0}, 8'd1);
      if (c == 6 || c == 8) chk("t1_busy", {7'd0, m_busy}, 8'd1);
      if (c == 7) chk("t1_prio_early", {6'd0, m_prio}, 8'd0);
      if (c == 8) chk("t1_prio", {6'd0, m_prio}, 8'h2);
      if (c == 9) chk("t1_idle", {6'd0, m_busy, 1'b0}, 8'd0);
      next_cycle();
    end

    // 2: div on lane 0 and mul on lane 1 together at c10
    do_reset();
    for (int c = 0; c <= 50; c++) begin
      drive(c == 10, 1, c >= 10 && c <= 44, 0, 0, 0, 0);
      @(negedge clk);
      if (c == 10) chk("t2_grant0", {6'd0, grant0, grant1}, 8'h2);
      if (c == 10 || c == 43) chk("t2_stall1", {7'd0, stall1}, 8'd1);
      if (c == 44) chk("t2_grant1", {6'd0, grant0, grant1}, 8'h1);
      if (c == 44) chk("t2_prio0", {6'd0, m_prio}, 8'h2);
      if (c == 46) chk("t2_prio_gap", {6'd0, m_prio}, 8'd0);
      if (c == 47) chk("t2_prio1", {6'd0, m_prio}, 8'h3);
      next_cycle();
    end

    // 3: lane-1 multiply with ex_stall over the DONE cycles
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      drive(0, 0, c == 0, 0, c == 3 || c == 4, 0, 0);
      @(negedge clk);
      if (c >= 3 && c <= 5) chk("t3_prio_hold", {6'd0, m_prio}, 8'h3);
      if (c == 6) chk("t3_busy", {6'd0, m_busy, m_prio != 2'b00}, 8'd0);
      next_cycle();
    end

    // 4: divide flushed at c12; waiting lane-1 op goes in at c13
    do_reset();
    for (int c = 0; c <= 40; c++) begin
      drive(c == 0, 1, c >= 5 && c <= 13, 0, 0, c == 12, 0);
      @(negedge clk);
      if (c == 12) chk("t4_no_grant", {6'd0, grant0, grant1}, 8'd0);
      if (c == 13) chk("t4_busy", {7'd0, m_busy}, 8'd0);
      if (c == 13) chk("t4_grant1", {7'd0, grant1}, 8'd1);
      if (c == 16) chk("t4_prio1", {6'd0, m_prio}, 8'h3);
      if (c == 34) chk("t4_no_div", {6'd0, m_prio}, 8'd0);
      next_cycle();
    end

    // 5: reset in the middle of a divide
    do_reset();
    for (int c = 0; c <= 40; c++) begin
      drive(c == 0, 1, c == 20, 0, 0, 0, c == 20);
      @(negedge clk);
      if (c == 20) chk("t5_rst_grant", {7'd0, grant1}, 8'd0);
      if (c == 21) chk("t5_busy", {7'd0, m_busy}, 8'd0);
      if (c == 34) chk("t5_prio", {6'd0, m_prio}, 8'd0);
      next_cycle();
    end

    // 6: three back-to-back lane-1 multiplies
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      drive(0, 0, c <= 6, 0, 0, 0, 0);
      @(negedge clk);
      if (c == 0 || c == 3 || c == 6) chk("t6_grant1", {7'd0, grant1}, 8'd1);
      if (c == 1) chk("t6_stall1", {7'd0, stall1}, 8'd1);
      if (c == 3 || c == 6 || c == 9) chk("t6_prio", {6'd0, m_prio}, 8'h3);
      if (c == 4) chk("t6_prio_gap", {6'd0, m_prio}, 8'd0);
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
